// File: rtl/sram_pkg.sv
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared state encoding, March C- element attributes and
//                background constants for the SRAM BIST controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        M0   = 4'd1,
        M1   = 4'd2,
        M2   = 4'd3,
        M3   = 4'd4,
        M4   = 4'd5,
        M5   = 4'd6,
        CMP  = 4'd7,
        FIN  = 4'd8
    } bist_state_e;

    // Backgrounds are sliced down to the SRAM word width at the point of use.
    localparam int                   BG_MAX_W = 256;
    localparam logic [BG_MAX_W-1:0]  BG0      = '0;
    localparam logic [BG_MAX_W-1:0]  BG1      = '1;

    function automatic logic elem_is_rw(input bist_state_e s);
        return (s == M1) || (s == M2) || (s == M3) || (s == M4);
    endfunction

    function automatic logic elem_is_down(input bist_state_e s);
        return (s == M3) || (s == M4);
    endfunction

    function automatic logic elem_rd_bg(input bist_state_e s);
        return (s == M2) || (s == M4);
    endfunction

    function automatic logic elem_wr_bg(input bist_state_e s);
        return (s == M1) || (s == M3);
    endfunction

    function automatic bist_state_e elem_next(input bist_state_e s);
        bist_state_e n;
        n = IDLE;
        case (s)
            M0:      n = M1;
            M1:      n = M2;
            M2:      n = M3;
            M3:      n = M4;
            M4:      n = M5;
            M5:      n = CMP;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bist_ctrl_if.sv
// ============================================================================
//  Module      : sram_bist_ctrl_if
//  Description : SRAM port bundle between the BIST controller and the SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_bist_ctrl_if #(
    parameter int depth = 256,
    parameter int width = 16
);
    localparam int AW = $clog2(depth);

    logic             cs;
    logic             we;
    logic             re;
    logic [AW-1:0]    add;
    logic [width-1:0] data_in;
    logic [width-1:0] data_out;

    modport master (output cs, we, re, add, data_in, input data_out);
    modport slave  (input cs, we, re, add, data_in, output data_out);

endinterface

`default_nettype wire

// File: rtl/sram_bist_addr_gen.sv
// ============================================================================
//  Module      : sram_bist_addr_gen
//  Description : Up/down address counter with load, enable and last flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bist_addr_gen #(
    parameter  int depth = 256,
    localparam int AW    = $clog2(depth)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_load,
    input  wire logic [AW-1:0] i_load_val,
    input  wire logic          i_en,
    input  wire logic          i_down,
    output logic      [AW-1:0] o_add,
    output logic               o_last
);

    localparam logic [AW-1:0] LAST_UP = AW'(depth - 1);

    logic [AW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= i_down ? (r_cnt - AW'(1)) : (r_cnt + AW'(1));
        end
    end

    assign o_add  = r_cnt;
    assign o_last = i_down ? (r_cnt == '0) : (r_cnt == LAST_UP);

endmodule

`default_nettype wire

// File: rtl/sram_bist_ctrl.sv
// ============================================================================
//  Module      : sram_bist_ctrl
//  Description : March C- SRAM BIST controller. Define SRAM_BIST_DIAG_EN to
//                add first-failure capture outputs (fail_add/exp/act).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_bist_ctrl
    import sram_pkg::*;
#(
    parameter int depth = 256,
    parameter int width = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    sram_bist_ctrl_if.master        sram,
    output logic                    busy,
    output logic                    done,
    output logic                    pass
`ifdef SRAM_BIST_DIAG_EN
    ,
    output logic [$clog2(depth)-1:0] fail_add,
    output logic [width-1:0]         fail_exp,
    output logic [width-1:0]         fail_act
`endif
);

    localparam int AW = $clog2(depth);

    bist_state_e      r_state, w_state_nxt;
    logic             r_phase;
    logic             r_chk;
    logic             r_exp_bg;
    logic             r_fail;
    logic             r_pass;
    logic [AW-1:0]    w_add;
    logic [AW-1:0]    w_load_val;
    logic             w_last, w_load, w_en;
    logic             w_active, w_rw, w_re, w_we, w_step;
    logic             w_start_acc, w_mismatch;
    logic [width-1:0] w_exp_word;

    sram_bist_addr_gen #(.depth(depth)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .i_down     (elem_is_down(r_state)),
        .o_add      (w_add),
        .o_last     (w_last)
    );

    assign w_active    = (r_state == M0) || (r_state == M5) || elem_is_rw(r_state);
    assign w_rw        = elem_is_rw(r_state);
    // Read-write elements read on phase 0 and write the same address on phase 1.
    assign w_re        = w_active && ((r_state == M5) || (w_rw && !r_phase));
    assign w_we        = w_active && !w_re;
    assign w_step      = w_active && (!w_rw || r_phase);
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_exp_word  = r_exp_bg ? BG1[width-1:0] : BG0[width-1:0];
    assign w_mismatch  = r_chk && (sram.data_out != w_exp_word);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = M0;
                    w_load      = 1'b1;
                end
            end
            M0, M1, M2, M3, M4, M5: begin
                w_en = w_step;
                if (w_step && w_last) begin
                    w_state_nxt = elem_next(r_state);
                    w_load      = 1'b1;
                    w_load_val  = elem_is_down(w_state_nxt) ? AW'(depth - 1) : '0;
                end
            end
            CMP:     w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_phase  <= 1'b0;
            r_chk    <= 1'b0;
            r_exp_bg <= 1'b0;
            r_fail   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_rw && !r_phase;
            r_chk    <= w_re;
            r_exp_bg <= elem_rd_bg(r_state);
            if (w_start_acc) begin
                r_fail <= 1'b0;
                r_pass <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    r_fail <= 1'b1;
                end
                // CMP checks the last M5 read, so fold its result in here.
                if (r_state == CMP) begin
                    r_pass <= !(r_fail || w_mismatch);
                end
            end
        end
    end

    assign sram.cs      = w_active;
    assign sram.we      = w_we;
    assign sram.re      = w_re;
    assign sram.add     = w_add;
    assign sram.data_in = w_we ? (elem_wr_bg(r_state) ? BG1[width-1:0] : BG0[width-1:0])
                               : '0;

    assign busy = w_active || (r_state == CMP);
    assign done = (r_state == FIN);
    assign pass = r_pass;

`ifdef SRAM_BIST_DIAG_EN
    logic [AW-1:0]    r_chk_add;
    logic [AW-1:0]    r_fail_add;
    logic [width-1:0] r_fail_exp;
    logic [width-1:0] r_fail_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_add  <= '0;
            r_fail_add <= '0;
            r_fail_exp <= '0;
            r_fail_act <= '0;
        end else begin
            r_chk_add <= w_add;
            if (w_start_acc) begin
                r_fail_add <= '0;
                r_fail_exp <= '0;
                r_fail_act <= '0;
            end else if (w_mismatch && !r_fail) begin
                r_fail_add <= r_chk_add;
                r_fail_exp <= w_exp_word;
                r_fail_act <= sram.data_out;
            end
        end
    end

    assign fail_add = r_fail_add;
    assign fail_exp = r_fail_exp;
    assign fail_act = r_fail_act;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_bist_ctrl.sv
// ============================================================================
//  Module      : tb_sram_bist_ctrl
//  Description : Scoreboard bench for sram_bist_ctrl with a faultable SRAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_bist_ctrl;

    localparam int DEPTH    = 8;
    localparam int WIDTH    = 16;
    localparam int AW       = 3;
    localparam int BUSY_LEN = 10 * DEPTH + 1;

    typedef struct {
        logic             we;
        logic [AW-1:0]    add;
        logic [WIDTH-1:0] data;
    } op_t;

    typedef struct {
        logic             pass;
        int               done_cyc;
        logic [AW-1:0]    fa;
        logic [WIDTH-1:0] fe;
        logic [WIDTH-1:0] fact;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, done, pass;
`ifdef SRAM_BIST_DIAG_EN
    logic [AW-1:0]    fail_add;
    logic [WIDTH-1:0] fail_exp, fail_act;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    op_t  op_q[$];
    res_t res_q[$];

    logic fault_en  = 1'b0;
    int   fault_a   = 0;
    int   fault_b   = 0;
    logic fault_v   = 1'b0;

    sram_bist_ctrl_if #(.depth(DEPTH), .width(WIDTH)) bus ();

    sram_bist_ctrl #(.depth(DEPTH), .width(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sram     (bus),
        .busy     (busy),
        .done     (done),
        .pass     (pass)
`ifdef SRAM_BIST_DIAG_EN
        ,
        .fail_add (fail_add),
        .fail_exp (fail_exp),
        .fail_act (fail_act)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WIDTH-1:0] apply_fault(input logic [WIDTH-1:0] w, input int a,
                                                     input logic en, input int fa, input int fb,
                                                     input logic fv);
        logic [WIDTH-1:0] r;
        r = w;
        if (en && a == fa) r[fb] = fv;
        return r;
    endfunction

    // Synchronous SRAM: read data appears the cycle after re is sampled.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata = '0;
    always @(posedge clk) begin
        if (bus.cs && bus.we) mem[bus.add] <= bus.data_in;
        if (bus.cs && bus.re) rdata <= apply_fault(mem[bus.add], int'(bus.add),
                                                   fault_en, fault_a, fault_b, fault_v);
    end
    assign bus.data_out = rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // March C- written out as element tables over a plain word array.
    task automatic push_expect(input logic f_en, input int f_a, input int f_b,
                               input logic f_v, output logic exp_pass);
        logic [WIDTH-1:0] m [DEPTH];
        int   rd_bg [6] = '{-1, 0, 1, 0, 1, 0};
        int   wr_bg [6] = '{ 0, 1, 0, 1, 0, -1};
        bit   dn    [6] = '{ 0, 0, 0, 1, 1, 0};
        res_t r;
        op_t  o;
        r.pass = 1'b1; r.done_cyc = -1; r.fa = '0; r.fe = '0; r.fact = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                int a;
                logic [WIDTH-1:0] exp_w, got;
                a = dn[e] ? (DEPTH - 1 - k) : k;
                if (rd_bg[e] >= 0) begin
                    exp_w = (rd_bg[e] == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    got   = apply_fault(m[a], a, f_en, f_a, f_b, f_v);
                    o.we = 1'b0; o.add = AW'(a); o.data = '0;
                    op_q.push_back(o);
                    if (got !== exp_w && r.pass) begin
                        r.pass = 1'b0; r.fa = AW'(a); r.fe = exp_w; r.fact = got;
                    end
                end
                if (wr_bg[e] >= 0) begin
                    o.we = 1'b1; o.add = AW'(a);
                    o.data = (wr_bg[e] == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    op_q.push_back(o);
                    m[a] = o.data;
                end
            end
        end
        res_q.push_back(r);
        exp_pass = r.pass;
    endtask

    // Call at a negedge while the DUT is idle; returns after the accepting edge.
    task automatic launch(input logic f_en, input int f_a, input int f_b, input logic f_v,
                          output logic exp_pass);
        fault_en = f_en; fault_a = f_a; fault_b = f_b; fault_v = f_v;
        push_expect(f_en, f_a, f_b, f_v, exp_pass);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        res_q[res_q.size() - 1].done_cyc = cyc + BUSY_LEN;
    endtask

    task automatic wait_done(input logic exp_pass);
        int n = 0;
        while (!done && n < 2 * BUSY_LEN) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", n);
        end
        @(negedge clk);
        chk("pass_hold", pass, exp_pass);
    endtask

    // Monitor: pops the expected SRAM operation / result whenever the DUT presents one.
    int busy_cnt = 0;
    int last_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            chk("we_re_excl", bus.we && bus.re, 1'b0);
            if (bus.cs) begin
                chk("cs_implies_busy", busy, 1'b1);
                if (op_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL op_unexpected: got cs=1 add=%0d expected no access", bus.add);
                end else begin
                    op_t o;
                    o = op_q.pop_front();
                    chk("sram_op", {bus.we, bus.re, bus.add, bus.data_in},
                        {o.we, !o.we, o.add, o.data});
                end
            end else if (busy) begin
                chk("cmp_slot", {op_q.size() == 0, busy_cnt == BUSY_LEN - 1}, 2'b11);
            end else begin
                chk("idle_quiet", {bus.we, bus.re, bus.data_in}, '0);
            end
            if (busy) begin
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                last_len = busy_cnt;
                busy_cnt = 0;
            end
            if (done) begin
                chk("done_busy", busy, 1'b0);
                if (res_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("pass", pass, r.pass);
                    chk("busy_len", last_len, BUSY_LEN);
                    chk("done_cycle", cyc, r.done_cyc);
`ifdef SRAM_BIST_DIAG_EN
                    chk("diag", {fail_add, fail_exp, fail_act}, {r.fa, r.fe, r.fact});
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ep;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs", {bus.cs, bus.we, bus.re, bus.add, bus.data_in, busy, done, pass}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free run, then a stuck-at-1 on bit 3 of word 5.
        launch(1'b0, 0, 0, 1'b0, ep);
        wait_done(ep);
        launch(1'b1, 5, 3, 1'b1, ep);
        wait_done(ep);
        chk("stuck_pass", pass, 1'b0);
`ifdef SRAM_BIST_DIAG_EN
        chk("stuck_diag", {fail_add, fail_exp, fail_act}, {3'd5, 16'h0000, 16'h0008});
`endif

        // Reset in busy cycle 30, then start on the first edge after release.
        launch(1'b0, 0, 0, 1'b0, ep);
        repeat (29) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midtest_reset",
            {bus.cs, bus.we, bus.re, bus.add, bus.data_in, busy, done, pass}, '0);
        op_q.delete();
        res_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        launch(1'b0, 0, 0, 1'b0, ep);
        wait_done(ep);
        chk("post_reset_pass", pass, 1'b1);

        // Start pulse in busy cycle 10 must not disturb the run.
        launch(1'b0, 0, 0, 1'b0, ep);
        repeat (9) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(ep);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            launch($urandom_range(0, 3) != 0, int'($urandom_range(0, DEPTH - 1)),
                   int'($urandom_range(0, WIDTH - 1)), 1'($urandom_range(0, 1)), ep);
            wait_done(ep);
        end

        repeat (2) @(negedge clk);
        chk("queues_drained", {op_q.size() == 0, res_q.size() == 0}, 2'b11);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_bist_ctrl.md
SRAM_BIST_CTRL -- requirements
Module: sram_bist_ctrl

Interface
REQ-001 SHALL have parameter depth, default 256, number of SRAM words tested.
REQ-002 SHALL have parameter width, default 16, SRAM word width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  test request; sampled only in IDLE.
REQ-006 SHALL have port cs  output  1  SRAM chip select, to the SRAM port.
REQ-007 SHALL have port we  output  1  SRAM write enable, to the SRAM port.
REQ-008 SHALL have port re  output  1  SRAM read enable, to the SRAM port.
REQ-009 SHALL have port add  output  $clog2(depth)  SRAM address, to the SRAM port.
REQ-010 SHALL have port data_in  output  width  SRAM write data, to the SRAM port.
REQ-011 SHALL have port data_out  input  width  SRAM read data, valid one cycle after re is sampled.
REQ-012 SHALL have port busy  output  1  high while the test runs.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port pass  output  1  result; valid from done until the next accepted start.

Function
REQ-015 SHALL run March C- as states IDLE, M0 (up: w0), M1 (up: r0,w1), M2 (up: r1,w0), M3 (down: r0,w1), M4 (down: r1,w0), M5 (up: r0), CMP, FIN.
REQ-016 SHALL use all-zeros as background 0 and all-ones as background 1.
REQ-017 SHALL issue exactly one SRAM operation per cycle in M0-M5, with cs=1 and exactly one of we/re high; cs=we=re=0 in IDLE, CMP, FIN.
REQ-018 SHALL, in read-write elements, issue the read on add=a in cycle t and the write to the same a in cycle t+1, then move to the next address.
REQ-019 SHALL compare data_out against the expected background in the cycle after every read; CMP covers the final M5 read.
REQ-020 SHALL step up elements 0..depth-1 and down elements depth-1..0, and enter the next element on the cycle after the last address without idle cycles.
REQ-021 SHALL take start=1 in IDLE to M0 at add=0 on the next cycle; start in any other state is ignored.
REQ-022 SHALL hold busy high for exactly 10*depth+1 cycles (M0 through CMP); FIN asserts done for one cycle with busy=0, then returns to IDLE.
REQ-023 SHALL clear an internal fail flag on accepted start, set it sticky on any mismatch, always run to completion, and drive pass = not fail at FIN.
REQ-024 SHALL drive data_in to the write background during writes and to zero otherwise.

Reset
REQ-025 SHALL, while rst_n=0, force IDLE, cs=we=re=0, add=0, data_in=0, busy=0, done=0, pass=0, fail flag cleared, including when reset occurs mid-test.
REQ-026 SHALL accept a new start on the first rising clk edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when SRAM_BIST_DIAG_EN is defined, add outputs fail_add ($clog2(depth)), fail_exp (width) and fail_act (width), capturing the first mismatch only, held until the next accepted start, and zero after reset.
REQ-028 SHALL, when SRAM_BIST_DIAG_EN is undefined, omit those ports and their capture logic entirely.

Structure
REQ-029 SHALL place the state encoding and the background constants (BG0, BG1 width-parameterised) in shared package sram_pkg.
REQ-030 SHALL implement addressing in sub-module sram_bist_addr_gen, an up/down counter with load, enable and last-address flag.

Verification
REQ-031 SHALL cover the fault-free case: depth=8, width=16, ideal SRAM model, start pulse -> busy for 81 cycles, done for one cycle, pass=1.
REQ-032 SHALL cover a stuck-at fault: bit 3 stuck at 1 at add=5 -> pass=0; with diag enabled, fail_add=5, fail_exp=16'h0000, fail_act=16'h0008 from the first M1 read.
REQ-033 SHALL cover reset mid-test: rst_n low at busy cycle 30 -> all outputs 0 immediately; a subsequent start completes with pass=1.
REQ-034 SHALL cover start while busy: a second start at busy cycle 10 -> a single done pulse at the same cycle as the unperturbed run.
REQ-035 SHALL cover the protocol check: every cycle has no we&re and cs==busy except in CMP; M3 address sequence is 7,7,6,6,...,0,0; M1 address sequence is 0,0,1,1,...,7,7.
